uart_tx_block: RTL and testbench

Serial transmitter that frames a parallel byte as start bit, data bits LSB first, optional even parity, and stop bit on a single line, with each bit held for a programmable number of clock cycles. It is the transmit-side counterpart of the lab UART receive path and sits between a parallel data source and the serial output pin. Internal bit-period and bit-index counting follow the flex-counter rollover style.

---
 rtl/uart_tx_block.sv | 116 +++++++++++
 tb/tb_uart_tx_block.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_block.sv
// UART transmitter: frames a parallel word as start, LSB-first data, optional
// even parity and stop bit, each bit held for BIT_PERIOD clock cycles.
module uart_tx_block #(
    parameter int unsigned BIT_PERIOD = 10,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY_EN  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_start,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 serial_out
);

    localparam int unsigned CNT_W = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     bit_cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 par_bit;
    logic                 bit_tick;
    logic                 last_bit;

    // bit_cnt runs 0..BIT_PERIOD-1 (the 1..BIT_PERIOD count offset by one); its wrap ends a bit
    assign bit_tick = (bit_cnt == CNT_W'(BIT_PERIOD - 1));
    assign last_bit = (bit_idx == IDX_W'(DATA_BITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            par_bit    <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            if (state != IDLE) begin
                bit_cnt <= bit_tick ? '0 : bit_cnt + CNT_W'(1);
            end
            case (state)
                IDLE: begin
                    serial_out <= 1'b1;
                    busy       <= 1'b0;
                    if (tx_start) begin
                        shreg      <= tx_data;
                        par_bit    <= ^tx_data;
                        bit_cnt    <= '0;
                        serial_out <= 1'b0;
                        busy       <= 1'b1;
                        state      <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state      <= DATA;
                        bit_idx    <= '0;
                        serial_out <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (last_bit) begin
                            if (PARITY_EN != 0) begin
                                state      <= PARITY;
                                serial_out <= par_bit;
                            end else begin
                                state      <= STOP;
                                serial_out <= 1'b1;
                            end
                        end else begin
                            // next data bit sits in shreg[1] before the shift lands
                            bit_idx    <= bit_idx + IDX_W'(1);
                            shreg      <= shreg >> 1;
                            serial_out <= shreg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bit_tick) begin
                        state      <= STOP;
                        serial_out <= 1'b1;
                    end
                end
                STOP: begin
                    if (bit_tick) begin
                        state      <= IDLE;
                        busy       <= 1'b0;
                        tx_done    <= 1'b1;
                        serial_out <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    serial_out <= 1'b1;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_block.sv
// Bench for uart_tx_block: per-cycle expected line levels are queued when a
// frame is launched and popped/compared at each negedge while it is sent.
module tb_uart_tx_block;

    localparam int unsigned BP = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       tx_start_p;
    logic       busy, tx_done, serial_out;
    logic       p_busy, p_tx_done, p_serial_out;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_block #(.BIT_PERIOD(BP), .DATA_BITS(8), .PARITY_EN(0)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start),
        .busy(busy), .tx_done(tx_done), .serial_out(serial_out)
    );

    uart_tx_block #(.BIT_PERIOD(BP), .DATA_BITS(8), .PARITY_EN(1)) dut_p (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_start(tx_start_p),
        .busy(p_busy), .tx_done(p_tx_done), .serial_out(p_serial_out)
    );

    task automatic push_level(input bit lvl);
        for (int c = 0; c < int'(BP); c++) exp_q.push_back(lvl);
    endtask

    task automatic push_frame(input logic [7:0] d, input bit par);
        push_level(1'b0);
        for (int i = 0; i < 8; i++) push_level(d[i]);
        if (par) push_level(^d);
        push_level(1'b1);
    endtask

    task automatic start_frame(input logic [7:0] d, input bit sel, input bit hold,
                               output int acc);
        @(negedge clk);
        tx_data = d;
        if (sel) tx_start_p = 1'b1; else tx_start = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        if (!hold) begin
            tx_start   = 1'b0;
            tx_start_p = 1'b0;
        end
    endtask

    // Pops the whole queue one level per cycle, then checks the done cycle.
    task automatic drain(input string name, input bit sel, input int inject,
                         output int done_cyc);
        int   idx = 0;
        bit   exp;
        logic so, bz, dn;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            so  = sel ? p_serial_out : serial_out;
            bz  = sel ? p_busy : busy;
            dn  = sel ? p_tx_done : tx_done;
            checks++;
            if (so !== exp || bz !== 1'b1 || dn !== 1'b0) begin
                errors++;
                $display("FAIL %s cycle %0d: serial_out=%b busy=%b tx_done=%b, expected %b 1 0",
                         name, idx, so, bz, dn, exp);
            end
            if (idx == inject) begin
                tx_data  = 8'hFF;
                tx_start = 1'b1;
            end else if (idx == inject + 1) begin
                tx_start = 1'b0;
            end
            idx++;
        end
        @(negedge clk);
        so = sel ? p_serial_out : serial_out;
        bz = sel ? p_busy : busy;
        dn = sel ? p_tx_done : tx_done;
        done_cyc = cyc;
        checks++;
        if (so !== 1'b1 || bz !== 1'b0 || dn !== 1'b1) begin
            errors++;
            $display("FAIL %s end: serial_out=%b busy=%b tx_done=%b, expected 1 0 1",
                     name, so, bz, dn);
        end
    endtask

    task automatic check_quiet(input string name, input int n);
        int bad = 0;
        repeat (n) begin
            @(negedge clk);
            if (serial_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 ||
                p_serial_out !== 1'b1 || p_busy !== 1'b0 || p_tx_done !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL %s: %0d non-idle cycles seen, expected 0", name, bad);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; tx_start = 1'b0; tx_start_p = 1'b0; tx_data = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (serial_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: serial_out=%b busy=%b tx_done=%b, expected 1 0 0",
                     serial_out, busy, tx_done);
        end
        check_quiet("reset_idle_hold", 10);
    endtask

    task automatic test_single();
        int acc, dc;
        push_frame(8'hA5, 1'b0);
        start_frame(8'hA5, 1'b0, 1'b0, acc);
        drain("single_A5", 1'b0, -10, dc);
        checks++;
        if (dc - acc != 40) begin
            errors++;
            $display("FAIL single_done_edge: done at +%0d, expected +40", dc - acc);
        end
        check_quiet("single_after", 5);
    endtask

    task automatic test_busy_ignore();
        int acc, dc;
        push_frame(8'h3C, 1'b0);
        start_frame(8'h3C, 1'b0, 1'b0, acc);
        drain("busy_ignore_3C", 1'b0, int'(BP) + 2 * int'(BP), dc);
        check_quiet("busy_ignore_no_second_frame", 10);
        checks++;
        if (dc - acc != 40) begin
            errors++;
            $display("FAIL busy_ignore_done_edge: done at +%0d, expected +40", dc - acc);
        end
    endtask

    task automatic test_back_to_back();
        int acc0, acc1, dc0, dc1;
        push_frame(8'h00, 1'b0);
        start_frame(8'h00, 1'b0, 1'b1, acc0);
        tx_data = 8'hFF;
        drain("b2b_first_00", 1'b0, -10, dc0);
        @(posedge clk);
        #1;
        acc1 = cyc;
        tx_start = 1'b0;
        push_frame(8'hFF, 1'b0);
        drain("b2b_second_FF", 1'b0, -10, dc1);
        checks++;
        if (acc1 - acc0 != 41) begin
            errors++;
            $display("FAIL b2b_start_gap: second start at +%0d, expected +41", acc1 - acc0);
        end
        checks++;
        if (dc1 - dc0 != 41) begin
            errors++;
            $display("FAIL b2b_done_gap: tx_done gap %0d, expected 41", dc1 - dc0);
        end
        check_quiet("b2b_after", 5);
    endtask

    task automatic test_parity();
        int acc, dc;
        push_frame(8'h07, 1'b1);
        start_frame(8'h07, 1'b1, 1'b0, acc);
        drain("parity_07", 1'b1, -10, dc);
        checks++;
        if (dc - acc != 44) begin
            errors++;
            $display("FAIL parity_done_edge: done at +%0d, expected +44", dc - acc);
        end
        check_quiet("parity_after", 5);
    endtask

    task automatic test_mid_reset();
        int   acc, dc;
        bit   exp;
        push_frame(8'hC3, 1'b0);
        start_frame(8'hC3, 1'b0, 1'b0, acc);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            exp = exp_q.pop_front();
            checks++;
            if (serial_out !== exp || busy !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset_pre cycle %0d: serial_out=%b busy=%b, expected %b 1",
                         i, serial_out, busy, exp);
            end
        end
        exp_q.delete();
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++;
        if (serial_out !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_abort: serial_out=%b busy=%b tx_done=%b, expected 1 0 0",
                     serial_out, busy, tx_done);
        end
        check_quiet("mid_reset_no_done", 50);
        push_frame(8'h5A, 1'b0);
        start_frame(8'h5A, 1'b0, 1'b0, acc);
        drain("mid_reset_new_5A", 1'b0, -10, dc);
        checks++;
        if (dc - acc != 40) begin
            errors++;
            $display("FAIL mid_reset_new_done_edge: done at +%0d, expected +40", dc - acc);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_busy_ignore();
        test_back_to_back();
        test_parity();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
